// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller.
package fetch_ctrl_pkg;

  localparam int          INST_W       = 32;
  localparam logic [63:0] PC_ENTRY_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port: one request at a time, response after grant.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
);
  logic              req;
  logic [WIDTH-1:0]  addr;
  logic              gnt;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_ctrl_redirect_sel.sv
// Fixed-priority redirect mux: exception > exception-return > branch.
module pc_redirect_sel #(
  parameter int WIDTH = 64
) (
  input  logic             ex,
  input  logic [WIDTH-1:0] ex_entry,
  input  logic             ex_ret,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             redirect,
  output logic [WIDTH-1:0] tgt
);

  // Pick the winning target and force word alignment.
  always_comb begin
    redirect = ex | ex_ret | br_taken;
    if (ex)          tgt = ex_entry;
    else if (ex_ret) tgt = epc;
    else             tgt = br_target;
    tgt[1:0] = 2'b00;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues single imem requests, buffers one word.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int             WIDTH    = 64,
  parameter logic [WIDTH-1:0] PC_ENTRY = WIDTH'(PC_ENTRY_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex,
  input  logic [WIDTH-1:0]  ex_entry,
  input  logic              ex_ret,
  input  logic [WIDTH-1:0]  epc,
  input  logic              br_taken,
  input  logic [WIDTH-1:0]  br_target,
  fetch_ctrl_if.master      imem,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [WIDTH-1:0]  inst_pc,
  input  logic              inst_ready,
  output logic [WIDTH-1:0]  pc
);

  fetch_state_e      state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [WIDTH-1:0]  inst_pc_q, inst_pc_d;
  logic              req_c;
  logic              redirect;
  logic [WIDTH-1:0]  tgt;

  pc_redirect_sel #(.WIDTH(WIDTH)) u_sel (
    .ex        (ex),
    .ex_entry  (ex_entry),
    .ex_ret    (ex_ret),
    .epc       (epc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .redirect  (redirect),
    .tgt       (tgt)
  );

  // Next-state, PC/kill update and buffer load; kill marks a response made stale.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    req_c      = 1'b0;
    inst_valid = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        req_c = 1'b1;
        if (redirect) pc_d = tgt;
        if (imem.gnt) begin
          state_d = WAIT;
          kill_d  = redirect;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d   = tgt;
          kill_d = 1'b1;
        end
        if (imem.rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d    = imem.rdata;
            inst_pc_d = pc_q;
            state_d   = VALID;
          end
        end
      end
      VALID: begin
        // A redirect hides the buffered word so decode never consumes it.
        inst_valid = !redirect;
        if (redirect) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + WIDTH'(4);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= PC_ENTRY;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign imem.req  = req_c;
  assign imem.addr = pc_q;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed corner sequences, a redirect-priority table,
// and a randomized run against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [63:0] ENTRY = 64'h8000_0000;

  logic        clk, rst;
  logic        ex, ex_ret, br_taken, inst_ready;
  logic [63:0] ex_entry, epc, br_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc, pc;

  int total = 0;
  int bad   = 0;

  fetch_ctrl_if #(.WIDTH(64)) imem ();

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ex         (ex),
    .ex_entry   (ex_entry),
    .ex_ret     (ex_ret),
    .epc        (epc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem       (imem.master),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        e, r, b;
    logic [63:0] ee, ep, bt, exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ex = 0; ex_ret = 0; br_taken = 0; inst_ready = 0;
    imem.gnt = 0; imem.rvalid = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   64'(imem.req),   64'd0);
    chk({tag, "_ivld"},  64'(inst_valid), 64'd0);
    chk({tag, "_inst"},  64'(inst),       64'd0);
    chk({tag, "_ipc"},   inst_pc,         64'd0);
    chk({tag, "_pc"},    pc,              ENTRY);
  endtask

  // Reset, release, and step into the first request cycle.
  task automatic do_reset();
    rst = 1; clr();
    cyc(); cyc();
    chk_reset_vals("rst");
    rst = 0;
    cyc();
  endtask

  // From a request cycle: grant, then respond one cycle later.
  task automatic fetch_to_valid(input logic [31:0] w);
    imem.gnt = 1; cyc();
    imem.gnt = 0; imem.rvalid = 1; imem.rdata = w; cyc();
    imem.rvalid = 0;
  endtask

  function automatic logic [63:0] model_tgt(input bit e, input bit r,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    logic [63:0] t;
    if (e)      t = a;
    else if (r) t = b;
    else        t = c;
    return (t / 4) * 4;
  endfunction

  // reference model state
  bit          m_boot, m_out, m_hold, m_stale, stale_before, redir, do_rst;
  logic [63:0] m_pc, m_buf, m_bpc, old_pc, t;
  int          rsp_cnt;

  vec_t vt[5];

  initial begin
    rst = 1; clr();
    ex_entry = 0; epc = 0; br_target = 0; imem.rdata = 0;
    vt[0] = '{1, 0, 0, 64'h8000_2003, 64'h0, 64'h0, 64'h8000_2000};
    vt[1] = '{0, 1, 0, 64'h0, 64'h8000_0045, 64'h0, 64'h8000_0044};
    vt[2] = '{0, 0, 1, 64'h0, 64'h0, 64'h8000_000A, 64'h8000_0008};
    vt[3] = '{0, 1, 1, 64'h0, 64'h8000_0200, 64'h8000_0300, 64'h8000_0200};
    vt[4] = '{1, 1, 1, 64'h8000_3000, 64'h8000_4000, 64'h8000_5000, 64'h8000_3000};

    // 1: first fetch and handshake
    do_reset();
    #1;
    chk("t1_req",  64'(imem.req), 64'd1);
    chk("t1_addr", imem.addr, ENTRY);
    fetch_to_valid(32'h0000_0013);
    inst_ready = 1; #1;
    chk("t1_ivld", 64'(inst_valid), 64'd1);
    chk("t1_inst", 64'(inst), 64'h13);
    chk("t1_ipc",  inst_pc, ENTRY);
    cyc(); inst_ready = 0; #1;
    chk("t1_next", imem.addr, 64'h8000_0004);
    chk("t1_req2", 64'(imem.req), 64'd1);

    // 2: branch while waiting kills the response
    imem.gnt = 1; cyc();
    imem.gnt = 0; br_taken = 1; br_target = 64'h8000_0102; cyc();
    br_taken = 0; imem.rvalid = 1; imem.rdata = 32'hBAD0_0001; #1;
    chk("t2_req_wait", 64'(imem.req), 64'd0);
    cyc(); imem.rvalid = 0; #1;
    chk("t2_ivld", 64'(inst_valid), 64'd0);
    chk("t2_addr", imem.addr, 64'h8000_0100);
    chk("t2_req",  64'(imem.req), 64'd1);

    // 3: exception beats branch
    ex = 1; br_taken = 1; ex_entry = 64'h8000_1000; br_target = 64'h8000_0500; cyc();
    clr(); #1;
    chk("t3_pc",   pc, 64'h8000_1000);
    chk("t3_addr", imem.addr, 64'h8000_1000);

    // 4: decode stall, then exception return
    fetch_to_valid(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_inst", 64'(inst), 64'hDEAD_BEEF);
      chk("t4_ipc",  inst_pc, 64'h8000_1000);
      chk("t4_req",  64'(imem.req), 64'd0);
      chk("t4_ivld", 64'(inst_valid), 64'd1);
      cyc();
    end
    ex_ret = 1; epc = 64'h8000_0040; #1;
    chk("t4_mask", 64'(inst_valid), 64'd0);
    cyc(); clr(); #1;
    chk("t4_addr", imem.addr, 64'h8000_0040);
    chk("t4_req2", 64'(imem.req), 64'd1);

    // redirect priority table, applied from a buffered word
    for (int i = 0; i < 5; i++) begin
      fetch_to_valid(32'(i));
      ex = vt[i].e; ex_ret = vt[i].r; br_taken = vt[i].b;
      ex_entry = vt[i].ee; epc = vt[i].ep; br_target = vt[i].bt; #1;
      chk("tbl_mask", 64'(inst_valid), 64'd0);
      cyc(); clr(); #1;
      chk("tbl_addr", imem.addr, vt[i].exp);
      chk("tbl_req",  64'(imem.req), 64'd1);
    end

    // 6: PC wraps to zero
    br_taken = 1; br_target = 64'hFFFF_FFFF_FFFF_FFFF; cyc(); clr(); #1;
    chk("t6_top", imem.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_to_valid(32'h1234_5678);
    inst_ready = 1; cyc(); inst_ready = 0; #1;
    chk("t6_wrap", imem.addr, 64'h0);

    // 5: reset while waiting, stray response afterwards
    imem.gnt = 1; cyc(); imem.gnt = 0;
    rst = 1; #1;
    chk_reset_vals("t5_async");
    cyc();
    rst = 0; imem.rvalid = 1; imem.rdata = 32'hFFFF_0000; #1;
    chk("t5_idle_req", 64'(imem.req), 64'd0);
    cyc(); #1;
    chk("t5_req",  64'(imem.req), 64'd1);
    chk("t5_addr", imem.addr, ENTRY);
    cyc(); imem.rvalid = 0; #1;
    chk("t5_ivld", 64'(inst_valid), 64'd0);
    chk("t5_req2", 64'(imem.req), 64'd1);
    chk("t5_addr2", imem.addr, ENTRY);

    // randomized run against the reference model
    rst = 1; clr(); cyc();
    m_boot = 1; m_out = 0; m_hold = 0; m_stale = 0;
    m_pc = ENTRY; m_buf = 0; m_bpc = 0; rsp_cnt = 0;
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      do_rst = ($urandom_range(0, 399) == 0);
      imem.rvalid = 0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) imem.rvalid = 1;
      end
      if (!m_out && $urandom_range(0, 7) == 0) imem.rvalid = 1;
      rst        = do_rst;
      ex         = ($urandom_range(0, 11) == 0);
      ex_ret     = ($urandom_range(0, 11) == 0);
      br_taken   = ($urandom_range(0, 7) == 0);
      ex_entry   = {$urandom, $urandom};
      epc        = {$urandom, $urandom};
      br_target  = {$urandom, $urandom};
      imem.gnt   = 1'($urandom_range(0, 1));
      inst_ready = 1'($urandom_range(0, 1));
      imem.rdata = $urandom;
      #1;
      if (do_rst) begin
        chk_reset_vals("rnd_rst");
        m_boot = 1; m_out = 0; m_hold = 0; m_stale = 0;
        m_pc = ENTRY; m_buf = 0; m_bpc = 0; rsp_cnt = 0;
      end else begin
        redir = ex | ex_ret | br_taken;
        chk("rnd_req",  64'(imem.req), 64'(!m_boot && !m_out && !m_hold));
        chk("rnd_addr", imem.addr, m_pc);
        chk("rnd_pc",   pc, m_pc);
        chk("rnd_ivld", 64'(inst_valid), 64'(m_hold && !redir));
        chk("rnd_inst", 64'(inst), m_buf);
        chk("rnd_ipc",  inst_pc, m_bpc);
        t = model_tgt(ex, ex_ret, ex_entry, epc, br_target);
        if (m_boot) begin
          m_boot = 0;
        end else if (!m_out && !m_hold) begin
          if (redir) m_pc = t;
          if (imem.gnt) begin
            m_out   = 1;
            m_stale = redir;
            rsp_cnt = $urandom_range(1, 3);
          end
        end else if (m_out) begin
          old_pc       = m_pc;
          stale_before = m_stale;
          if (redir) begin
            m_pc    = t;
            m_stale = 1;
          end
          if (imem.rvalid) begin
            m_out = 0;
            if (stale_before || redir) m_stale = 0;
            else begin
              m_hold = 1;
              m_buf  = 64'(imem.rdata);
              m_bpc  = old_pc;
            end
          end
        end else begin
          if (redir) begin
            m_hold = 0;
            m_pc   = t;
          end else if (inst_ready) begin
            m_hold = 0;
            m_pc   = m_pc + 64'd4;
          end
        end
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
